// File: rtl/fp_pkg.sv
// fp_pkg: shared FSM state encoding, default widths and constants for fp_addsub_seq
//   MANT_W_DEF / EXP_W_DEF : default mantissa / exponent widths
//   EXP_MAX                : largest representable exponent at the default width
//   MANT_ONE               : mantissa value 1.0 (lowest integer bit) at the default width
package fp_pkg;
  localparam int MANT_W_DEF = 16;
  localparam int EXP_W_DEF = 8;
  localparam int EXP_MAX = (1 << EXP_W_DEF) - 1;
  localparam int MANT_ONE = 1 << (MANT_W_DEF - 2);
  typedef enum logic [2:0] {IDLE, CMP, ALIGN, ADD, NORM, DONE} state_t;
endpackage

// File: rtl/fp_mag_addsub.sv
// fp_mag_addsub: combinational signed-magnitude add/subtract of two aligned mantissas
//   a, b   : magnitudes (b already aligned to a's exponent)
//   sa, sb : effective signs of a and b
//   sum    : MANT_W+1-bit magnitude result (carry kept)
//   sgn    : result sign (sign of the larger magnitude when signs differ)
module fp_mag_addsub import fp_pkg::*; #(
  parameter int MANT_W = MANT_W_DEF
) (
  input  logic [MANT_W-1:0] a,
  input  logic [MANT_W-1:0] b,
  input  logic              sa,
  input  logic              sb,
  output logic [MANT_W:0]   sum,
  output logic              sgn
);
  logic ge;
  assign ge = a >= b;
  assign sum = (sa == sb) ? {1'b0, a} + {1'b0, b} : ge ? {1'b0, a} - {1'b0, b} : {1'b0, b} - {1'b0, a};
  assign sgn = (sa == sb || ge) ? sa : sb;
endmodule

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle floating-point add/subtract (compare, align, add, normalize)
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid / in_ready      : operand handshake (ready only in IDLE)
//   inp1/sgn1/exp1, inp2/sgn2/exp2 : operand magnitude, sign, exponent
//   sub                      : 1 -> op1-op2, 0 -> op1+op2
//   out_valid / out_ready    : result handshake (results held while waiting)
//   out, sgnout, outexp      : result magnitude, sign, exponent
//   ovf, unf, zero           : exponent overflow, exponent underflow, zero result
module fp_addsub_seq import fp_pkg::*; #(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W = EXP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] inp1,
  input  logic [MANT_W-1:0] inp2,
  input  logic              sgn1,
  input  logic              sgn2,
  input  logic [EXP_W-1:0]  exp1,
  input  logic [EXP_W-1:0]  exp2,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out,
  output logic              sgnout,
  output logic [EXP_W-1:0]  outexp,
  output logic              ovf,
  output logic              unf,
  output logic              zero
);
  localparam int EMAX_I = (EXP_W == EXP_W_DEF) ? EXP_MAX : (1 << EXP_W) - 1;
  localparam int ONE_I = (MANT_W == MANT_W_DEF) ? MANT_ONE : 1 << (MANT_W - 2);
  localparam logic [EXP_W-1:0] EMAX = EXP_W'(EMAX_I);
  localparam logic [MANT_W:0] ONE = (MANT_W + 1)'(ONE_I);
  localparam logic [EXP_W-1:0] E1 = EXP_W'(1);
  state_t state, state_n;
  // ma/ea/sa hold operand A; after ADD, ea/sa are reused as the result exponent/sign
  logic [MANT_W-1:0] ma, mb, ma_n, mb_n, out_n;
  logic [EXP_W-1:0] ea, eb, ea_n, eb_n, diff, diff_n, outexp_n, d;
  logic sa, sb, sa_n, sb_n, sgnout_n, ovf_n, unf_n, zero_n;
  logic [MANT_W:0] sum, sum_n, sum_w;
  logic sgn_w, swap, far;
  fp_mag_addsub #(.MANT_W(MANT_W)) u_mag (
    .a(ma),
    .b(mb),
    .sa(sa),
    .sb(sb),
    .sum(sum_w),
    .sgn(sgn_w)
  );
  assign in_ready = state == IDLE && !rst;
  assign out_valid = state == DONE;
  assign swap = eb > ea || (eb == ea && mb > ma);
  assign d = swap ? eb - ea : ea - eb;
  // B would be shifted out entirely: drop it and skip alignment
  assign far = int'(d) >= MANT_W;
  always_comb begin
    state_n = state;
    ma_n = ma;
    mb_n = mb;
    ea_n = ea;
    eb_n = eb;
    sa_n = sa;
    sb_n = sb;
    diff_n = diff;
    sum_n = sum;
    out_n = out;
    outexp_n = outexp;
    sgnout_n = sgnout;
    ovf_n = ovf;
    unf_n = unf;
    zero_n = zero;
    case (state)
      IDLE: if (in_valid) begin
        state_n = CMP;
        ma_n = inp1;
        ea_n = exp1;
        sa_n = sgn1;
        mb_n = inp2;
        eb_n = exp2;
        sb_n = sgn2 ^ sub;
        ovf_n = 1'b0;
        unf_n = 1'b0;
        zero_n = 1'b0;
      end
      CMP: begin
        ma_n = swap ? mb : ma;
        ea_n = swap ? eb : ea;
        sa_n = swap ? sb : sa;
        mb_n = far ? '0 : swap ? ma : mb;
        eb_n = swap ? ea : eb;
        sb_n = swap ? sa : sb;
        diff_n = far ? '0 : d;
        state_n = (far || d == '0) ? ADD : ALIGN;
      end
      ALIGN: begin
        mb_n = diff != '0 ? mb >> 1 : mb;
        diff_n = diff != '0 ? diff - E1 : diff;
        state_n = diff <= E1 ? ADD : ALIGN;
      end
      ADD: begin
        sum_n = sum_w;
        sa_n = sgn_w;
        state_n = NORM;
      end
      NORM: begin
        if (|sum[MANT_W:MANT_W-1]) begin
          if (ea == EMAX) begin
            ovf_n = 1'b1;
            out_n = '1;
            outexp_n = EMAX;
            sgnout_n = sa;
            state_n = DONE;
          end else begin
            sum_n = sum >> 1;
            ea_n = ea + E1;
          end
        end else if (!(|(sum & ONE)) && sum != '0) begin
          if (ea == '0) begin
            unf_n = 1'b1;
            out_n = sum[MANT_W-1:0];
            outexp_n = '0;
            sgnout_n = sa;
            state_n = DONE;
          end else begin
            sum_n = sum << 1;
            ea_n = ea - E1;
          end
        end else begin
          zero_n = sum == '0;
          out_n = sum[MANT_W-1:0];
          outexp_n = sum == '0 ? '0 : ea;
          sgnout_n = sa && sum != '0;
          state_n = DONE;
        end
      end
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= '0;
      mb <= '0;
      ea <= '0;
      eb <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      diff <= '0;
      sum <= '0;
      out <= '0;
      outexp <= '0;
      sgnout <= 1'b0;
      ovf <= 1'b0;
      unf <= 1'b0;
      zero <= 1'b0;
    end else begin
      ma <= ma_n;
      mb <= mb_n;
      ea <= ea_n;
      eb <= eb_n;
      sa <= sa_n;
      sb <= sb_n;
      diff <= diff_n;
      sum <= sum_n;
      out <= out_n;
      outexp <= outexp_n;
      sgnout <= sgnout_n;
      ovf <= ovf_n;
      unf <= unf_n;
      zero <= zero_n;
    end
  end
endmodule

// File: doc/fp_addsub_seq.md
FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

Interface
REQ-001 SHALL have parameter MANT_W, default 16, mantissa width; bits [MANT_W-1:MANT_W-2] are integer bits, the rest are fraction.
REQ-002 SHALL have parameter EXP_W, default 8, unsigned exponent width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1): operand handshake.
REQ-007 SHALL have ports inp1, inp2 (input, MANT_W): operand magnitudes.
REQ-008 SHALL have ports sgn1, sgn2 (input, 1): operand signs.
REQ-009 SHALL have ports exp1, exp2 (input, EXP_W): operand exponents.
REQ-010 SHALL have port sub, input, 1: 1 computes op1-op2, 0 computes op1+op2.
REQ-011 SHALL have ports out_valid (output, 1) and out_ready (input, 1): result handshake.
REQ-012 SHALL have ports out (MANT_W), sgnout (1), outexp (EXP_W), all outputs: result.
REQ-013 SHALL have ports ovf, unf, zero, all output, 1: result flags.

Function
REQ-014 An operand transfer SHALL occur on in_valid&&in_ready; in_ready SHALL be 1 only in IDLE; in IDLE all operands and sub SHALL be registered and the effective sign of op2 SHALL be sgn2^sub.
REQ-015 The FSM SHALL have the states IDLE, CMP, ALIGN, ADD, NORM and DONE, with one transition per clock.
REQ-016 In CMP, the operands SHALL be swapped so that A has exp >= B's exp (on equal exponents, the larger magnitude is A); diff SHALL be expA-expB; if diff >= MANT_W, B's mantissa SHALL be zeroed and diff cleared.
REQ-017 In ALIGN, B's mantissa SHALL be shifted right by 1 per cycle (truncating) and diff decremented; the state SHALL exit to ADD when diff==0, and SHALL skip straight to ADD when diff==0 on entry.
REQ-018 In ADD, equal effective signs SHALL give sum=A+B; unequal signs SHALL give sum=|A|-|B| with the sign of the larger magnitude; sum SHALL be MANT_W+1 bits wide and the result exponent SHALL be expA.
REQ-019 In NORM, the following SHALL apply once per cycle:
- If sum[MANT_W:MANT_W-1]!=0, shift right by 1 and exp+1.
- Else, if sum[MANT_W-2]==0 and sum!=0, shift left by 1 and exp-1.
- Else, go to DONE.
REQ-020 A sum of zero SHALL yield out=0, outexp=0, sgnout=0, zero=1.
REQ-021 If the exponent would exceed 2^EXP_W-1, the FSM SHALL saturate outexp at the maximum, set out to all ones and ovf=1, and go to DONE.
REQ-022 If a left shift is needed with exp==0, the FSM SHALL stop normalizing, set unf=1, and keep the denormal mantissa.
REQ-023 In DONE, out_valid SHALL be 1 and all outputs SHALL be stable until out_ready; on out_valid&&out_ready the FSM SHALL go to IDLE; there is no back-to-back accept in the same cycle.
REQ-024 Latency from accept to out_valid SHALL be 3 + min(diff, MANT_W-1 when not zeroed) + normalization steps, counted in cycles (CMP 1, ALIGN n, ADD 1, NORM k+1).
REQ-025 Flags SHALL be cleared on each accept.

Reset
REQ-026 On rst asserted at any time, including mid-operation, the FSM SHALL go to IDLE immediately.
REQ-027 While in reset, in_ready=0, out_valid=0, out=0, sgnout=0, outexp=0, ovf=0, unf=0, zero=0, and all internal registers SHALL be 0.
REQ-028 After reset deasserts, in_ready SHALL rise in the first cycle; a transaction in flight at reset SHALL be discarded with no out_valid.

Structure
REQ-029 Package fp_pkg SHALL hold the state enum, the MANT_W/EXP_W defaults, and the constants EXP_MAX and MANT_ONE (1<<(MANT_W-2)).
REQ-030 The sub-module fp_mag_addsub SHALL be the combinational MANT_W+1-bit magnitude add/subtract with sign select, used in the ADD state.
REQ-031 Everything else SHALL be in a single FSM with a datapath register block.

Verification
REQ-032 Equal-exponent add: 0x4000 e10 + 0x4000 e10, sub=0 -> out=0x4000, outexp=11, sgnout=0; out_valid 4 cycles after accept.
REQ-033 Alignment: 0x4000 e12 + 0x4000 e10 -> B aligned to 0x1000, out=0x5000, outexp=12; out_valid 5 cycles after accept.
REQ-034 Cancellation: 0x6000 e9 - 0x6000 e9 -> out=0, outexp=0, sgnout=0, zero=1.
REQ-035 Left normalization: 0x4000 e10 - 0x3000 e10 -> out=0x4000, outexp=8, sgnout=0.
REQ-036 Large diff and sign: 0x4000 e40, sgn1=1, + 0x4000 e20 -> B zeroed, out=0x4000, outexp=40, sgnout=1; then 0x4000 e255 + 0x4000 e255 -> ovf=1, outexp=255.
REQ-037 Backpressure/reset: hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0; assert rst during ALIGN -> IDLE next, out_valid never rises.
